// File: rtl/axi_wr_master.sv
// Single-outstanding AXI4 INCR write master: command plus data stream in, bursts out, split at 4KB.
// Define AXI_WR_MASTER_TOUT_EN to abandon a command after TOUT cycles without a write response.
module axi_wr_master #(
    parameter int AWID  = 32,
    parameter int IDWID = 4,
    parameter int DWID  = 64,
    parameter int WSTRB = DWID / 8
`ifdef AXI_WR_MASTER_TOUT_EN
    ,
    parameter int TOUT  = 1024
`endif
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [AWID-1:0]  cmd_addr,
    input  logic [7:0]       cmd_len,
    input  logic [IDWID-1:0] cmd_id,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [DWID-1:0]  din,
    input  logic [WSTRB-1:0] din_strb,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             done,
    output logic [1:0]       done_resp,
    output logic [IDWID-1:0] done_id,
    output logic             busy,
    output logic [IDWID-1:0] awid,
    output logic [AWID-1:0]  awaddr,
    output logic [7:0]       awlen,
    output logic [2:0]       awsize,
    output logic [1:0]       awburst,
    output logic             awvalid,
    input  logic             awready,
    output logic [DWID-1:0]  wdata,
    output logic [WSTRB-1:0] wstrb,
    output logic             wlast,
    output logic             wvalid,
    input  logic             wready,
    input  logic [IDWID-1:0] bid,
    input  logic [1:0]       bresp,
    input  logic             bvalid,
    output logic             bready
);

    typedef enum logic [1:0] {S_IDLE, S_AW, S_W, S_B} state_t;

    state_t           state_q;
    logic [IDWID-1:0] id_q, done_id_q;
    logic [AWID-1:0]  addr_q;
    logic [8:0]       rem_q, blen_q, cnt_q;
    logic [7:0]       awlen_q;
    logic [1:0]       worst_q, done_resp_q;
    logic             awvalid_q, bready_q, done_q;
`ifdef AXI_WR_MASTER_TOUT_EN
    logic [15:0]      tcnt_q;
`endif

    logic [AWID-1:0]  cmd_addr_al, addr_d;
    logic [8:0]       cmd_rem, rem_d, blen_first, blen_next;
    logic [1:0]       resp_eff, worst_d;
    logic             w_hs;

    // Beats left before the next 4KB page, capped by what the command still needs.
    function automatic logic [8:0] burst_len(input logic [8:0] word_idx, input logic [8:0] rem);
        logic [9:0] room;
        room = 10'd512 - {1'b0, word_idx};
        return ({1'b0, rem} < room) ? rem : room[8:0];
    endfunction

    always_comb begin
        cmd_addr_al = cmd_addr & ~AWID'(7);
        cmd_rem     = {1'b0, cmd_len} + 9'd1;
        blen_first  = burst_len(cmd_addr_al[11:3], cmd_rem);
        resp_eff    = (bid != id_q) ? 2'b10 : bresp;
        worst_d     = (resp_eff > worst_q) ? resp_eff : worst_q;
        addr_d      = addr_q + AWID'({blen_q, 3'b000});
        rem_d       = rem_q - blen_q;
        blen_next   = burst_len(addr_d[11:3], rem_d);
    end

    assign w_hs      = (state_q == S_W) && din_valid && wready;
    assign cmd_ready = (state_q == S_IDLE);
    assign busy      = (state_q != S_IDLE);
    assign din_ready = (state_q == S_W) && wready;
    assign wvalid    = (state_q == S_W) && din_valid;
    assign wlast     = (state_q == S_W) && (cnt_q == 9'd1);
    assign wdata     = din;
    assign wstrb     = din_strb;
    assign awid      = id_q;
    assign awaddr    = addr_q;
    assign awlen     = awlen_q;
    assign awsize    = 3'd3;
    assign awburst   = 2'd1;
    assign awvalid   = awvalid_q;
    assign bready    = bready_q;
    assign done      = done_q;
    assign done_resp = done_resp_q;
    assign done_id   = done_id_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            id_q        <= '0;
            addr_q      <= '0;
            rem_q       <= '0;
            blen_q      <= '0;
            cnt_q       <= '0;
            awlen_q     <= '0;
            worst_q     <= '0;
            awvalid_q   <= 1'b0;
            bready_q    <= 1'b0;
            done_q      <= 1'b0;
            done_resp_q <= '0;
            done_id_q   <= '0;
`ifdef AXI_WR_MASTER_TOUT_EN
            tcnt_q      <= '0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (cmd_valid) begin
                        id_q      <= cmd_id;
                        addr_q    <= cmd_addr_al;
                        rem_q     <= cmd_rem;
                        worst_q   <= 2'b00;
                        blen_q    <= blen_first;
                        awlen_q   <= 8'(blen_first - 9'd1);
                        awvalid_q <= 1'b1;
                        state_q   <= S_AW;
                    end
                end
                S_AW: begin
                    if (awready) begin
                        awvalid_q <= 1'b0;
                        cnt_q     <= blen_q;
                        state_q   <= S_W;
                    end
                end
                S_W: begin
                    if (w_hs) begin
                        cnt_q <= cnt_q - 9'd1;
                        if (cnt_q == 9'd1) begin
                            bready_q <= 1'b1;
                            state_q  <= S_B;
`ifdef AXI_WR_MASTER_TOUT_EN
                            tcnt_q   <= '0;
`endif
                        end
                    end
                end
                S_B: begin
`ifdef AXI_WR_MASTER_TOUT_EN
                    tcnt_q <= tcnt_q + 16'd1;
`endif
                    if (bvalid) begin
                        bready_q <= 1'b0;
                        worst_q  <= worst_d;
                        addr_q   <= addr_d;
                        rem_q    <= rem_d;
                        if (rem_d != 9'd0) begin
                            blen_q    <= blen_next;
                            awlen_q   <= 8'(blen_next - 9'd1);
                            awvalid_q <= 1'b1;
                            state_q   <= S_AW;
                        end else begin
                            done_q      <= 1'b1;
                            done_resp_q <= worst_d;
                            done_id_q   <= id_q;
                            state_q     <= S_IDLE;
                        end
                    end
`ifdef AXI_WR_MASTER_TOUT_EN
                    else if (tcnt_q == 16'(TOUT - 1)) begin
                        bready_q    <= 1'b0;
                        done_q      <= 1'b1;
                        done_resp_q <= 2'b11;
                        done_id_q   <= id_q;
                        state_q     <= S_IDLE;
                    end
`endif
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_wr_master.sv
// Bench for axi_wr_master: table vectors, hand sequences and random commands against a
// burst-splitting reference model and a behavioural AXI slave with a word-addressed RAM.
module tb_axi_wr_master;
    localparam int AWID  = 32;
    localparam int IDWID = 4;
    localparam int DWID  = 64;
    localparam int WSTRB = 8;
`ifdef AXI_WR_MASTER_TOUT_EN
    localparam int TOUT  = 40;
`endif

    logic             clk, rst_n;
    logic [AWID-1:0]  cmd_addr;
    logic [7:0]       cmd_len;
    logic [IDWID-1:0] cmd_id;
    logic             cmd_valid, cmd_ready;
    logic [DWID-1:0]  din;
    logic [WSTRB-1:0] din_strb;
    logic             din_valid, din_ready;
    logic             done, busy;
    logic [1:0]       done_resp;
    logic [IDWID-1:0] done_id, awid, bid;
    logic [AWID-1:0]  awaddr;
    logic [7:0]       awlen;
    logic [2:0]       awsize;
    logic [1:0]       awburst, bresp;
    logic             awvalid, awready;
    logic [DWID-1:0]  wdata;
    logic [WSTRB-1:0] wstrb;
    logic             wlast, wvalid, wready;
    logic             bvalid, bready;

    axi_wr_master #(
        .AWID(AWID), .IDWID(IDWID), .DWID(DWID), .WSTRB(WSTRB)
`ifdef AXI_WR_MASTER_TOUT_EN
        , .TOUT(TOUT)
`endif
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_id(cmd_id),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .din(din), .din_strb(din_strb), .din_valid(din_valid), .din_ready(din_ready),
        .done(done), .done_resp(done_resp), .done_id(done_id), .busy(busy),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [7:0]  len;
    } burst_t;

    typedef struct {
        logic [31:0] addr;
        logic [7:0]  len;
        logic [3:0]  id;
        bit          bad;
        int          resp;
        int          exp_bursts;
        logic [1:0]  exp_resp;
    } vec_t;

    int checks = 0;
    int errors = 0;

    burst_t      exp_bq[$];
    logic [63:0] din_q[$];
    logic [7:0]  strb_q[$];
    int unsigned beat_addr_q[$];
    logic [63:0] ram[int unsigned];
    logic [63:0] exp_mem[int unsigned];

    int          aw_stall, w_prob, d_prob, b_delay, resp_mode;
    bit          bad_id;
    int          aw_wait, b_pending, b_wait, cur_beats;
    int unsigned wptr;
    logic [3:0]  last_awid, cur_id;
    logic [1:0]  exp_worst, done_resp_obs;
    logic [3:0]  done_id_obs;
    int          done_cnt, beat_cnt, aw_cnt, aw_low_cnt;
    int          tick_no, cmd_tick, done_tick, aw_first_tick, last_w_tick;
    bit          cmd_pend, cmd_taken, b_hs, outstanding;
    logic [31:0] p_addr;
    logic [7:0]  p_len;
    logic [3:0]  p_id;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_cmd_ready"}, cmd_ready, 1);
        check({tag, "_awvalid"}, awvalid, 0);
        check({tag, "_wvalid"}, wvalid, 0);
        check({tag, "_wlast"}, wlast, 0);
        check({tag, "_bready"}, bready, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_din_ready"}, din_ready, 0);
        check({tag, "_awaddr"}, awaddr, 0);
        check({tag, "_awlen"}, awlen, 0);
        check({tag, "_awid"}, awid, 0);
        check({tag, "_done_resp"}, done_resp, 0);
        check({tag, "_done_id"}, done_id, 0);
    endtask

    // One clock: drive bench inputs at the falling edge, then judge what the next rising edge will take.
    task automatic tick();
        logic [1:0] r;
        @(negedge clk);
        tick_no++;
        if (cmd_pend) begin
            cmd_valid = 1'b1; cmd_addr = p_addr; cmd_len = p_len; cmd_id = p_id; cmd_pend = 0;
        end else if (cmd_taken) begin
            cmd_valid = 1'b0; cmd_taken = 0;
        end
        awready = 1'b0;
        if (awvalid) begin
            if (aw_wait >= aw_stall) awready = 1'b1;
            else aw_wait++;
        end
        wready = ($urandom_range(99) < w_prob);
        if (din_q.size() > 0 && $urandom_range(99) < d_prob) begin
            din_valid = 1'b1; din = din_q[0]; din_strb = strb_q[0];
        end else begin
            din_valid = 1'b0; din = '0; din_strb = '0;
        end
        if (b_hs) begin
            bvalid = 1'b0; b_hs = 0;
        end
        if (!bvalid && b_pending > 0) begin
            if (b_wait >= b_delay) begin
                bvalid = 1'b1;
                bresp  = (resp_mode == 4) ? 2'($urandom_range(3)) : 2'(resp_mode);
                bid    = bad_id ? (last_awid ^ 4'h1) : last_awid;
            end else b_wait++;
        end
        #1;
        if (done) begin
            done_cnt++; done_resp_obs = done_resp; done_id_obs = done_id; done_tick = tick_no;
            check("busy_at_done", busy, 0);
        end
        if (cmd_ready) check("din_ready_idle", din_ready, 0);
        if (din_ready) check("din_ready_follows_wready", wready, 1);
        if (awvalid) begin
            if (aw_first_tick < 0) aw_first_tick = tick_no;
            check("aw_before_b", outstanding, 0);
            if (exp_bq.size() == 0) check("aw_unexpected", 1, 0);
            else begin
                check("awaddr", awaddr, exp_bq[0].addr);
                check("awlen", awlen, exp_bq[0].len);
                check("awid", awid, cur_id);
                if (awready) begin
                    check("awsize", awsize, 3);
                    check("awburst", awburst, 1);
                    wptr = awaddr >> 3;
                    cur_beats = int'(exp_bq[0].len) + 1;
                    void'(exp_bq.pop_front());
                    aw_wait = 0; outstanding = 1; aw_cnt++; last_awid = awid;
                end else aw_low_cnt++;
            end
        end
        if ((wvalid && wready) || (din_valid && din_ready))
            check("w_hs_match", wvalid && wready, din_valid && din_ready);
        if (wvalid && wready) begin
            if (din_q.size() == 0 || cur_beats == 0) check("w_unexpected", 1, 0);
            else begin
                check("wdata", wdata, din_q[0]);
                check("wstrb", wstrb, strb_q[0]);
                check("wlast", wlast, cur_beats == 1);
                ram[wptr] = wdata;
                wptr++; cur_beats--; beat_cnt++; last_w_tick = tick_no;
                void'(din_q.pop_front()); void'(strb_q.pop_front());
                if (cur_beats == 0) begin b_pending++; b_wait = 0; end
            end
        end
        if (bvalid && bready) begin
            r = bad_id ? 2'b10 : bresp;
            if (r > exp_worst) exp_worst = r;
            b_hs = 1; b_pending--; outstanding = 0;
        end
        if (cmd_valid && cmd_ready) begin
            cmd_taken = 1; cmd_tick = tick_no;
        end
    endtask

    task automatic cleanup();
        exp_bq.delete(); din_q.delete(); strb_q.delete();
        b_pending = 0; b_wait = 0; b_hs = 0; cur_beats = 0; outstanding = 0;
        cmd_pend = 0; cmd_taken = 0; aw_wait = 0;
    endtask

    // Reference model: walk the command in page-bounded bursts and record every beat's word address.
    task automatic run_cmd(input logic [31:0] a, input logic [7:0] l, input logic [3:0] id,
                           input int stop_beats, input bit tout_mode, input int exp_override);
        logic [31:0] al;
        logic [63:0] d;
        int rem, room, bl, guard, mem_bad;
        al = a & 32'hFFFF_FFF8;
        rem = int'(l) + 1;
        exp_bq.delete(); beat_addr_q.delete(); exp_mem.delete();
        while (rem > 0) begin
            room = 512 - int'((al >> 3) & 32'h1FF);
            bl = (rem < room) ? rem : room;
            exp_bq.push_back('{al, 8'(bl - 1)});
            for (int k = 0; k < bl; k++) begin
                d = {$urandom, $urandom};
                din_q.push_back(d);
                strb_q.push_back(8'($urandom));
                exp_mem[(al >> 3) + k] = d;
                beat_addr_q.push_back((al >> 3) + k);
            end
            al = al + 32'(bl * 8);
            rem -= bl;
        end
        exp_worst = 2'b00; done_cnt = 0; beat_cnt = 0; aw_cnt = 0; aw_low_cnt = 0;
        aw_first_tick = -1; cur_id = id;
        p_addr = a; p_len = l; p_id = id; cmd_pend = 1;
        guard = 0;
        while (done_cnt == 0 && guard < 20000 && !(stop_beats > 0 && beat_cnt >= stop_beats)) begin
            tick();
            guard++;
        end
        if (stop_beats > 0) return;
        check("done_seen", done_cnt != 0, 1);
        repeat (3) tick();
        check("done_once", done_cnt, 1);
        check("done_resp", done_resp_obs, (exp_override >= 0) ? 2'(exp_override) : exp_worst);
        check("done_id", done_id_obs, id);
        check("idle_busy", busy, 0);
        check("idle_cmd_ready", cmd_ready, 1);
        if (!tout_mode) begin
            check("bursts_left", exp_bq.size(), 0);
            mem_bad = 0;
            foreach (beat_addr_q[i]) begin
                if (!ram.exists(beat_addr_q[i]) || ram[beat_addr_q[i]] !== exp_mem[beat_addr_q[i]])
                    mem_bad++;
            end
            check("ram_contents", mem_bad, 0);
        end
    endtask

    vec_t vt[8];

    initial begin
        vt[0] = '{32'h0000_0100, 8'd0,   4'h1, 1'b0, 0, 1, 2'b00};
        vt[1] = '{32'h0000_0000, 8'd15,  4'h2, 1'b0, 0, 1, 2'b00};
        vt[2] = '{32'h0000_0FF8, 8'd3,   4'h3, 1'b0, 0, 2, 2'b00};
        vt[3] = '{32'h0000_1000, 8'd255, 4'h4, 1'b0, 1, 1, 2'b01};
        vt[4] = '{32'h0000_1F08, 8'd255, 4'h5, 1'b0, 0, 2, 2'b00};
        vt[5] = '{32'h0000_0204, 8'd7,   4'h6, 1'b1, 0, 1, 2'b10};
        vt[6] = '{32'hFFFF_FFF8, 8'd1,   4'h7, 1'b0, 3, 2, 2'b11};
        vt[7] = '{32'h0000_0FF0, 8'd2,   4'h8, 1'b1, 3, 2, 2'b10};

        rst_n = 1'b0;
        cmd_addr = '0; cmd_len = '0; cmd_id = '0; cmd_valid = 1'b0;
        din = '0; din_strb = '0; din_valid = 1'b0;
        awready = 1'b0; wready = 1'b0;
        bid = '0; bresp = '0; bvalid = 1'b0;
        aw_stall = 0; w_prob = 100; d_prob = 100; b_delay = 0; resp_mode = 0; bad_id = 0;
        tick_no = 0; last_awid = '0; cur_id = '0; wptr = 0; last_w_tick = 0;
        cleanup();
        repeat (3) @(negedge clk);
        #1;
        check_reset_vals("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Zero-wait slave: single beat takes four cycles from command to done.
        run_cmd(32'h0000_0100, 8'd0, 4'h1, 0, 0, -1);
        check("lat_cmd_to_aw", 64'(aw_first_tick - cmd_tick), 1);
        check("lat_cmd_to_done", 64'(done_tick - cmd_tick), 4);

        // AW held off for five cycles with a toggling wready.
        aw_stall = 5; w_prob = 50; b_delay = 1;
        run_cmd(32'h0000_0040, 8'd7, 4'hA, 0, 0, -1);
        check("aw_stall_cycles", aw_low_cnt, 5);
        check("stall_beats", beat_cnt, 8);

        aw_stall = 1; w_prob = 70; d_prob = 80; b_delay = 2;
        for (int i = 0; i < 8; i++) begin
            bad_id = vt[i].bad;
            resp_mode = vt[i].resp;
            run_cmd(vt[i].addr, vt[i].len, vt[i].id, 0, 0, -1);
            check($sformatf("vec%0d_bursts", i), aw_cnt, vt[i].exp_bursts);
            check($sformatf("vec%0d_resp", i), done_resp_obs, vt[i].exp_resp);
        end
        bad_id = 0; resp_mode = 0;

        // Reset lands in the middle of an eight-beat burst.
        aw_stall = 0; w_prob = 100; d_prob = 100; b_delay = 0;
        run_cmd(32'h0000_0080, 8'd7, 4'h9, 3, 0, -1);
        rst_n = 1'b0;
        #1;
        check_reset_vals("midrst");
        cleanup();
        cmd_valid = 1'b0; din_valid = 1'b0; bvalid = 1'b0; awready = 1'b0; wready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        done_cnt = 0;
        repeat (5) tick();
        check("no_done_after_reset", done_cnt, 0);
        check("cmd_ready_after_reset", cmd_ready, 1);

        for (int i = 0; i < 25; i++) begin
            logic [31:0] a;
            logic [7:0]  l;
            a = {$urandom};
            if ($urandom_range(1) == 1) a = (a & 32'hFFFF_F000) | (32'h1000 - 32'(8 * $urandom_range(1, 40)));
            l = 8'($urandom_range(0, ($urandom_range(3) == 0) ? 255 : 20));
            aw_stall = $urandom_range(0, 3); w_prob = $urandom_range(40, 100);
            d_prob = $urandom_range(40, 100); b_delay = $urandom_range(0, 3);
            bad_id = ($urandom_range(5) == 0); resp_mode = 4;
            run_cmd(a, l, 4'($urandom), 0, 0, -1);
        end
        bad_id = 0; resp_mode = 0;

`ifdef AXI_WR_MASTER_TOUT_EN
        aw_stall = 0; w_prob = 100; d_prob = 100; b_delay = 1000000;
        run_cmd(32'h0000_0FF8, 8'd3, 4'hC, 0, 1, 3);
        check("tout_latency", 64'(done_tick - last_w_tick), TOUT + 1);
        cleanup();
        b_delay = 0;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
